dm_ctrl: RTL and testbench

//  Sequences and shares the word-wide, single-port data memory (dm) between two requesters.

---
 rtl/dm_ctrl_pkg.sv | 27 ++
 rtl/dm_ctrl_merge.sv | 24 ++
 rtl/dm_ctrl.sv | 116 +++++++++++
 tb/tb_dm_ctrl.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/dm_ctrl_pkg.sv
// Shared encodings and request struct for the data-memory sequencer.
package dm_ctrl_pkg;
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_XFER   = 2'd1;
  localparam logic [1:0] S_RMW_RD = 2'd2;
  localparam logic [1:0] S_RMW_WR = 2'd3;

  localparam logic PORT_A = 1'b0;
  localparam logic PORT_B = 1'b1;

  typedef struct packed {
    logic        we;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] pc;
  } dm_req_t;

  // Byte and half stores need a read-modify-write since dm writes whole words.
  function automatic logic is_sub(input logic [1:0] size);
    return (size == SZ_BYTE) || (size == SZ_HALF);
  endfunction
endpackage

// File: rtl/dm_ctrl_merge.sv
// Byte-lane merge of right-aligned store data into an old word.
module dm_ctrl_merge
  import dm_ctrl_pkg::*;
#(
  parameter int NUM_LANES = 4
) (
  input  logic [NUM_LANES-1:0][7:0] old_word,
  input  logic [31:0]               wdata,
  input  logic [1:0]                size,
  input  logic [1:0]                lane,
  output logic [NUM_LANES-1:0][7:0] new_word
);
  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    localparam logic [1:0] LI = 2'(i);
    logic       be;
    logic [7:0] src;
    // Half stores pick the lane pair by addr[1]; addr[0] is ignored.
    assign be  = (size == SZ_BYTE) ? (lane == LI) :
                 (size == SZ_HALF) ? (lane[1] == LI[1]) : 1'b1;
    assign src = (size == SZ_BYTE) ? wdata[7:0] :
                 (size == SZ_HALF) ? wdata[8*(i%2) +: 8] : wdata[8*i +: 8];
    assign new_word[i] = be ? src : old_word[i];
  end
endmodule

// File: rtl/dm_ctrl.sv
// Two-port sequencer for a word-wide single-port dm, with RMW for byte/half stores.
// Define DM_ARB_RR_EN for round-robin arbitration; default is fixed priority A over B.
module dm_ctrl
  import dm_ctrl_pkg::*;
#(
  parameter logic [31:0] DM_BASE  = 32'h0000_0000,
  parameter int          DM_WORDS = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        a_req,
  input  logic        a_we,
  input  logic [1:0]  a_size,
  input  logic [31:0] a_addr,
  input  logic [31:0] a_wdata,
  input  logic [31:0] a_pc,
  output logic        a_gnt,
  output logic        a_done,
  output logic [31:0] a_rdata,
  input  logic        b_req,
  input  logic        b_we,
  input  logic [1:0]  b_size,
  input  logic [31:0] b_addr,
  input  logic [31:0] b_wdata,
  input  logic [31:0] b_pc,
  output logic        b_gnt,
  output logic        b_done,
  output logic [31:0] b_rdata,
  output logic        dm_MemWrite,
  output logic [31:0] dm_PC,
  output logic [31:0] dm_addr,
  output logic [31:0] dm_writeData,
  input  logic [31:0] dm_readData
);
  logic [1:0]  state, state_nx;
  dm_req_t     lq, nreq;
  logic        lport, win_b, grant, oor;
  logic [31:0] rmw_q, merged;
  logic [32:0] off;

`ifdef DM_ARB_RR_EN
  logic rr_pri;
  assign win_b = b_req & (~a_req | (rr_pri == PORT_B));
`else
  assign win_b = b_req & ~a_req;
`endif

  assign grant = reset & (state == S_IDLE) & (a_req | b_req);
  assign a_gnt = grant & ~win_b;
  assign b_gnt = grant & win_b;
  assign nreq  = win_b ? {b_we, b_size, b_addr, b_wdata, b_pc}
                       : {a_we, a_size, a_addr, a_wdata, a_pc};

  // Borrow out of the offset means below base; otherwise compare against window size.
  assign off = {1'b0, lq.addr} - {1'b0, DM_BASE};
  assign oor = off[32] | (off[31:0] >= 32'(4 * DM_WORDS));

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:   if (grant) state_nx = (nreq.we && is_sub(nreq.size)) ? S_RMW_RD : S_XFER;
      S_XFER:   state_nx = S_IDLE;
      S_RMW_RD: state_nx = S_RMW_WR;
      default:  state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= S_IDLE;
      lq      <= '0;
      lport   <= PORT_A;
      rmw_q   <= '0;
      a_done  <= 1'b0;
      b_done  <= 1'b0;
      a_rdata <= '0;
      b_rdata <= '0;
`ifdef DM_ARB_RR_EN
      rr_pri  <= PORT_A;
`endif
    end else begin
      state  <= state_nx;
      a_done <= 1'b0;
      b_done <= 1'b0;
      if (grant) begin
        lq    <= nreq;
        lport <= win_b ? PORT_B : PORT_A;
`ifdef DM_ARB_RR_EN
        rr_pri <= win_b ? PORT_A : PORT_B;
`endif
      end
      if (state == S_RMW_RD) rmw_q <= dm_readData;
      if (state == S_XFER || state == S_RMW_WR) begin
        if (lport == PORT_B) b_done <= 1'b1;
        else                 a_done <= 1'b1;
        if (state == S_XFER && !lq.we) begin
          if (lport == PORT_B) b_rdata <= oor ? 32'h0 : dm_readData;
          else                 a_rdata <= oor ? 32'h0 : dm_readData;
        end
      end
    end
  end

  dm_ctrl_merge u_merge (
    .old_word (rmw_q),
    .wdata    (lq.wdata),
    .size     (lq.size),
    .lane     (lq.addr[1:0]),
    .new_word (merged)
  );

  assign dm_MemWrite  = ~oor & (((state == S_XFER) & lq.we) | (state == S_RMW_WR));
  assign dm_PC        = lq.pc;
  assign dm_addr      = {lq.addr[31:2], 2'b00};
  assign dm_writeData = (state == S_RMW_WR) ? merged : lq.wdata;
endmodule

// File: tb/tb_dm_ctrl.sv
// Directed bench for dm_ctrl with a behavioural word-wide dm.
module tb_dm_ctrl;
  logic        clk = 1'b0;
  logic        reset;
  logic        a_req, a_we, b_req, b_we;
  logic [1:0]  a_size, b_size;
  logic [31:0] a_addr, a_wdata, a_pc, b_addr, b_wdata, b_pc;
  logic        a_gnt, a_done, b_gnt, b_done;
  logic [31:0] a_rdata, b_rdata;
  logic        dm_MemWrite;
  logic [31:0] dm_PC, dm_addr, dm_writeData, dm_readData;

  logic [31:0] mem [0:1023];
  logic        pl_en = 1'b0;
  logic [9:0]  pl_idx;
  logic [31:0] pl_data;
  int          wr_cnt = 0;
  logic [31:0] wr_pc;
  int          ncmp = 0, nfail = 0;

  always #5 clk = ~clk;

  dm_ctrl dut (
    .clk(clk), .reset(reset),
    .a_req(a_req), .a_we(a_we), .a_size(a_size), .a_addr(a_addr), .a_wdata(a_wdata), .a_pc(a_pc),
    .a_gnt(a_gnt), .a_done(a_done), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_size(b_size), .b_addr(b_addr), .b_wdata(b_wdata), .b_pc(b_pc),
    .b_gnt(b_gnt), .b_done(b_done), .b_rdata(b_rdata),
    .dm_MemWrite(dm_MemWrite), .dm_PC(dm_PC), .dm_addr(dm_addr),
    .dm_writeData(dm_writeData), .dm_readData(dm_readData)
  );

  assign dm_readData = mem[dm_addr[11:2]];

  always @(posedge clk) begin
    if (pl_en) mem[pl_idx] <= pl_data;
    else if (dm_MemWrite) begin
      mem[dm_addr[11:2]] <= dm_writeData;
      wr_cnt <= wr_cnt + 1;
      wr_pc  <= dm_PC;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic preload(input logic [9:0] idx, input logic [31:0] d);
    @(negedge clk);
    pl_en = 1'b1; pl_idx = idx; pl_data = d;
    @(negedge clk);
    pl_en = 1'b0;
  endtask

  // Issue one request, wait for gnt, then measure cycles from gnt to done.
  task automatic xact(input logic port, input logic we, input logic [1:0] size,
                      input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [31:0] pc, input int exp_lat, input string tag);
    int lat;
    bit got;
    a_req = 1'b0; b_req = 1'b0;
    if (port) begin
      b_req = 1'b1; b_we = we; b_size = size; b_addr = addr; b_wdata = wdata; b_pc = pc;
    end else begin
      a_req = 1'b1; a_we = we; a_size = size; a_addr = addr; a_wdata = wdata; a_pc = pc;
    end
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      #1;
      if (port ? b_gnt : a_gnt) got = 1'b1;
      else @(negedge clk);
    end
    chk({tag, " gnt"}, 32'(got), 32'd1);
    lat = 0;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      lat++;
      a_req = 1'b0; b_req = 1'b0;
      #1;
      if (port ? b_done : a_done) got = 1'b1;
    end
    chk({tag, " latency"}, 32'(lat), 32'(exp_lat));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    int          wr0;
    logic [3:0]  seq;
    int          ng;
    bit          both;
    logic [3:0]  exp_seq;

    reset = 1'b0;
    a_req = 1'b0; a_we = 1'b0; a_size = 2'b10; a_addr = '0; a_wdata = '0; a_pc = '0;
    b_req = 1'b0; b_we = 1'b0; b_size = 2'b10; b_addr = '0; b_wdata = '0; b_pc = '0;
    repeat (2) @(negedge clk);
    a_req = 1'b1;
    #1;
    chk("rst a_gnt", 32'(a_gnt), 0);
    chk("rst done", {30'd0, a_done, b_done}, 0);
    chk("rst memwrite", 32'(dm_MemWrite), 0);
    chk("rst dm_addr", dm_addr, 0);
    chk("rst dm_wdata", dm_writeData, 0);
    chk("rst a_rdata", a_rdata, 0);
    a_req = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    // Word store then load at address 0
    wr0 = wr_cnt;
    xact(1'b0, 1'b1, 2'b10, 32'h0, 32'h1, 32'h1234, 2, "sw a");
    chk("sw writes", 32'(wr_cnt - wr0), 1);
    chk("sw mem0", mem[0], 32'h1);
    chk("sw pc", wr_pc, 32'h1234);
    xact(1'b0, 1'b0, 2'b10, 32'h0, 32'h0, 32'h0, 2, "lw a");
    chk("lw rdata", a_rdata, 32'h1);

    // Byte store RMW
    preload(10'd1, 32'h11223344);
    wr0 = wr_cnt;
    xact(1'b0, 1'b1, 2'b00, 32'h5, 32'hAB, 32'h0, 3, "sb a");
    chk("sb writes", 32'(wr_cnt - wr0), 1);
    chk("sb mem1", mem[1], 32'h1122AB44);

    // Half stores from B, addr[0] ignored, then low half from A
    preload(10'd1, 32'h11223344);
    xact(1'b1, 1'b1, 2'b01, 32'h6, 32'hBEEF, 32'h0, 3, "sh b 6");
    chk("sh6 mem1", mem[1], 32'hBEEF3344);
    preload(10'd1, 32'h11223344);
    xact(1'b1, 1'b1, 2'b01, 32'h7, 32'hBEEF, 32'h0, 3, "sh b 7");
    chk("sh7 mem1", mem[1], 32'hBEEF3344);
    xact(1'b0, 1'b1, 2'b01, 32'h4, 32'h1234DEAD, 32'h0, 3, "sh a 4");
    chk("sh4 mem1", mem[1], 32'hBEEFDEAD);
    xact(1'b1, 1'b0, 2'b10, 32'h4, 32'h0, 32'h0, 2, "lw b");
    chk("lw b rdata", b_rdata, 32'hBEEFDEAD);

    // Simultaneous requests held high; last grant was B
    @(negedge clk);
    a_req = 1'b1; a_we = 1'b0; a_size = 2'b10; a_addr = 32'h0;
    b_req = 1'b1; b_we = 1'b0; b_size = 2'b10; b_addr = 32'h4;
    seq = '0; ng = 0; both = 1'b0;
    for (int k = 0; k < 8; k++) begin
      #1;
      if (a_gnt && b_gnt) both = 1'b1;
      if ((a_gnt || b_gnt) && ng < 4) begin
        seq[ng] = b_gnt;
        ng++;
      end
      @(negedge clk);
    end
    a_req = 1'b0; b_req = 1'b0;
`ifdef DM_ARB_RR_EN
    exp_seq = 4'b1010;
`else
    exp_seq = 4'b0000;
`endif
    chk("arb grants", 32'(ng), 4);
    chk("arb order", 32'(seq), 32'(exp_seq));
    chk("arb exclusive", 32'(both), 0);
    repeat (3) @(negedge clk);

    // Out of range: first byte past the window, and the last valid word
    wr0 = wr_cnt;
    xact(1'b0, 1'b1, 2'b10, 32'h1000, 32'hDEADBEEF, 32'h0, 2, "oor sw");
    xact(1'b0, 1'b1, 2'b00, 32'h1001, 32'h77, 32'h0, 3, "oor sb");
    chk("oor writes", 32'(wr_cnt - wr0), 0);
    chk("oor mem0", mem[0], 32'h1);
    xact(1'b0, 1'b0, 2'b10, 32'h1000, 32'h0, 32'h0, 2, "oor lw");
    chk("oor rdata", a_rdata, 32'h0);
    wr0 = wr_cnt;
    xact(1'b0, 1'b1, 2'b10, 32'hFFC, 32'h5A5A5A5A, 32'h0, 2, "top sw");
    chk("top writes", 32'(wr_cnt - wr0), 1);
    chk("top mem", mem[1023], 32'h5A5A5A5A);

    // Reset during RMW_RD
    preload(10'd2, 32'hCAFEF00D);
    xact(1'b0, 1'b0, 2'b10, 32'h8, 32'h0, 32'h0, 2, "pre lw");
    chk("pre rdata", a_rdata, 32'hCAFEF00D);
    wr0 = wr_cnt;
    a_req = 1'b1; a_we = 1'b1; a_size = 2'b00; a_addr = 32'h9; a_wdata = 32'h55; a_pc = 32'h88;
    #1;
    chk("rmw gnt", 32'(a_gnt), 1);
    @(negedge clk);
    a_req = 1'b0;
    reset = 1'b0;
    #1;
    chk("mid rst memwrite", 32'(dm_MemWrite), 0);
    chk("mid rst dm_addr", dm_addr, 0);
    chk("mid rst dm_pc", dm_PC, 0);
    chk("mid rst dm_wdata", dm_writeData, 0);
    chk("mid rst a_rdata", a_rdata, 0);
    chk("mid rst b_rdata", b_rdata, 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("mid rst writes", 32'(wr_cnt - wr0), 0);
    chk("mid rst mem2", mem[2], 32'hCAFEF00D);
    xact(1'b0, 1'b0, 2'b10, 32'h8, 32'h0, 32'h0, 2, "post lw");
    chk("post rdata", a_rdata, 32'hCAFEF00D);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule
